fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Parametrised fetch/sequencing unit for the core: owns the program counter, jump resolution and the
//  req/done run handshake, replacing the fixed "PC==128" done test with a configurable end address,
//  halt input, stall support, a writable jump-target LUT and a watchdog. Sits between the decoder
//  (jump/halt strobes) and instr_ROM (prog_ctr).
// PARAMETERS
//  D          12   program counter width (bits)
//  L          5    jump-LUT index width; LUT depth = 2**L entries of D bits
//  START_ADDR 0    PC loaded on run start
//  END_ADDR   128  run completes when next PC equals this value
//  W          16   watchdog counter width; timeout after 2**W-1 RUN cycles
// PORTS
//  clk          in   1  clock, all state updates on posedge
//  reset        in   1  synchronous, active-high
//  req          in   1  run request (level)
//  done         out  1  run complete; held until req drops
//  busy         out  1  high while in RUN
//  timeout      out  1  run ended by watchdog; held until next run start
//  stall        in   1  freeze PC; jump/halt inputs ignored this cycle
//  halt         in   1  decoded halt instruction
//  absjump_en   in   1  take LUT target: PC <= lut[lut_idx]
//  reljump_en   in   1  relative jump: PC <= PC + rel_off
//  lut_idx      in   L  LUT read index for absolute jump
//  rel_off      in   D  signed two's-complement offset
//  lut_we       in   1  LUT write strobe
//  lut_waddr    in   L  LUT write index
//  lut_wdata    in   D  LUT write data
//  prog_ctr     out  D  current PC to instr_ROM
//  fetch_valid  out  1  prog_ctr addresses an instruction to execute this cycle
// BEHAVIOUR
//  Reset: state IDLE, prog_ctr=START_ADDR, done=busy=timeout=fetch_valid=0, watchdog=0. LUT contents not reset.
//  FSM IDLE/RUN/DONE. busy=(RUN); done=(DONE); fetch_valid=(RUN && !stall), combinational.
//  IDLE: req=1 -> RUN next edge; prog_ctr<=START_ADDR, watchdog<=0, timeout<=0. req=0 -> stay.
//  RUN, each edge, priority top-down:
//   1 watchdog==2**W-1 -> DONE, timeout<=1, PC holds (checked even when stall=1)
//   2 stall=1 -> PC holds, watchdog+1, stay RUN
//   3 halt=1 -> DONE, PC holds
//   4 next_pc = absjump_en ? lut[lut_idx] : reljump_en ? PC+rel_off : PC+1 (abs wins over rel)
//   5 next_pc==END_ADDR -> DONE with prog_ctr<=END_ADDR; else prog_ctr<=next_pc, stay RUN
//  Watchdog increments every RUN cycle (stalled or not), saturating, never wraps.
//  PC arithmetic modulo 2**D: 2**D-1 + 1 -> 0; rel_off sign-extended implicitly (D-bit add, carry dropped).
//  DONE: req=1 -> stay (no re-run while req held); req=0 -> IDLE next edge, done drops.
//  Jump/halt/stall inputs ignored outside RUN. req drop mid-RUN ignored (run finishes).
//  reset mid-run: next edge forces reset state regardless of FSM state; pending jump discarded.
//  LUT: synchronous write on lut_we (any state), combinational read; write and absjump to same
//   index in same cycle -> jump uses old entry, new entry visible next cycle.
//  Latency: req->busy 1 cycle; halt/end->done 1 cycle; done drop 1 cycle after req low.
// STRUCTURE
//  fetch_pkg: state enum {IDLE,RUN,DONE}, default D/L/W/START_ADDR/END_ADDR constants.
//  Sub-module jump_lut (2**L x D register array, 1 write port, 1 async read port); FSM, PC and
//  watchdog stay in fetch_sequencer.
// TESTING
//  T1 reset, req=1, no jumps -> busy at cycle 1, prog_ctr 0,1,..,127, then done=1, prog_ctr=128.
//  T2 lut[3]=40 written, at PC=5 absjump_en=1,reljump_en=1,lut_idx=3 -> next PC=40 (abs priority).
//  T3 PC=10, reljump_en, rel_off=-4 (12'hFFC) -> PC=6; PC=4095,+1 -> 0 with END_ADDR=128 not hit.
//  T4 stall for 3 cycles at PC=7 with halt=1 -> PC stays 7, fetch_valid=0; stall drops -> DONE.
//  T5 W=4, jump-to-self loop -> after 15 RUN cycles done=1,timeout=1; req low -> IDLE, timeout held
//   until next req.
//  T6 reset asserted in RUN at PC=50 -> next cycle IDLE, prog_ctr=0, busy=0; req still high -> restarts.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default parameter values for the fetch sequencer.
//   state_t      : sequencer FSM states
//   DEF_*        : default widths and run addresses
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_D          = 12;
    localparam int DEF_L          = 5;
    localparam int DEF_START_ADDR = 0;
    localparam int DEF_END_ADDR   = 128;
    localparam int DEF_W          = 16;

endpackage

// File: rtl/jump_lut.sv
// Jump-target lookup table: 2**L entries of D bits, one synchronous write
// port and one combinational read port. Contents are not reset.
//   clk    : clock
//   we     : write strobe
//   waddr  : write index
//   wdata  : write data
//   raddr  : read index
//   rdata  : read data (reflects writes from the next cycle on)
module jump_lut #(
    parameter int D = 12,
    parameter int L = 5
) (
    input  logic         clk,
    input  logic         we,
    input  logic [L-1:0] waddr,
    input  logic [D-1:0] wdata,
    input  logic [L-1:0] raddr,
    output logic [D-1:0] rdata
);

    logic [D-1:0] mem [2**L];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the program counter, resolves absolute/relative
// jumps, runs the req/done handshake and guards each run with a watchdog.
//   clk, reset                 : clock, synchronous active-high reset
//   req / done / busy          : run request, run complete, running
//   timeout                    : last run ended by the watchdog
//   stall, halt                : freeze PC / decoded halt
//   absjump_en, lut_idx        : jump to lut[lut_idx]
//   reljump_en, rel_off        : jump to PC + rel_off (two's complement)
//   lut_we, lut_waddr, lut_wdata : jump LUT write port
//   prog_ctr, fetch_valid      : PC to instr_ROM, PC is executed this cycle
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for req
// RUN     | fetching; PC advances, jumps, watchdog counting
// DONE    | run finished; held until req drops
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int D          = DEF_D,
    parameter int L          = DEF_L,
    parameter int START_ADDR = DEF_START_ADDR,
    parameter int END_ADDR   = DEF_END_ADDR,
    parameter int W          = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    output logic         done,
    output logic         busy,
    output logic         timeout,
    input  logic         stall,
    input  logic         halt,
    input  logic         absjump_en,
    input  logic         reljump_en,
    input  logic [L-1:0] lut_idx,
    input  logic [D-1:0] rel_off,
    input  logic         lut_we,
    input  logic [L-1:0] lut_waddr,
    input  logic [D-1:0] lut_wdata,
    output logic [D-1:0] prog_ctr,
    output logic         fetch_valid
);

    localparam logic [D-1:0] START_PC = D'(START_ADDR);
    localparam logic [D-1:0] END_PC   = D'(END_ADDR);
    localparam logic [W-1:0] WD_MAX   = '1;

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [W-1:0] wd_q, wd_d;
    logic         to_q, to_d;
    logic [D-1:0] lut_rdata;
    logic [D-1:0] next_pc;

    jump_lut #(.D(D), .L(L)) u_jump_lut (
        .clk   (clk),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (lut_idx),
        .rdata (lut_rdata)
    );

    // D-bit add drops the carry, so rel_off acts as a signed offset and
    // the PC wraps modulo 2**D.
    always_comb begin
        if (absjump_en) begin
            next_pc = lut_rdata;
        end else if (reljump_en) begin
            next_pc = pc_q + rel_off;
        end else begin
            next_pc = pc_q + D'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wd_d    = wd_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC;
                    wd_d    = '0;
                    to_d    = 1'b0;
                end
            end
            ST_RUN: begin
                // Watchdog counts stalled cycles too and saturates.
                if (wd_q != WD_MAX) begin
                    wd_d = wd_q + W'(1);
                end
                if (wd_q == WD_MAX) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                end else if (stall) begin
                    state_d = ST_RUN;
                end else if (halt) begin
                    state_d = ST_DONE;
                end else if (next_pc == END_PC) begin
                    state_d = ST_DONE;
                    pc_d    = END_PC;
                end else begin
                    pc_d    = next_pc;
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign timeout     = to_q;
    assign prog_ctr    = pc_q;
    assign fetch_valid = busy && !stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int D      = 12;
    localparam int L      = 5;
    localparam int W      = 8;
    localparam int START  = 0;
    localparam int ENDA   = 128;
    localparam int WD_MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0;
    logic         done, busy, timeout, fetch_valid;
    logic         stall = 1'b0, halt = 1'b0;
    logic         absjump_en = 1'b0, reljump_en = 1'b0;
    logic [L-1:0] lut_idx = '0;
    logic [D-1:0] rel_off = '0;
    logic         lut_we = 1'b0;
    logic [L-1:0] lut_waddr = '0;
    logic [D-1:0] lut_wdata = '0;
    logic [D-1:0] prog_ctr;

    int total = 0;
    int bad   = 0;

    // Reference model: run/done flags, PC, RUN-cycle count, LUT contents.
    bit           m_busy, m_done, m_to;
    logic [D-1:0] m_pc;
    int           m_run;
    logic [D-1:0] m_lut [1 << L];

    fetch_sequencer #(.D(D), .L(L), .START_ADDR(START), .END_ADDR(ENDA), .W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .busy(busy),
        .timeout(timeout), .stall(stall), .halt(halt),
        .absjump_en(absjump_en), .reljump_en(reljump_en),
        .lut_idx(lut_idx), .rel_off(rel_off), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .prog_ctr(prog_ctr), .fetch_valid(fetch_valid)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        logic [D-1:0] np;
        if (reset) begin
            m_busy = 0; m_done = 0; m_to = 0; m_pc = D'(START); m_run = 0;
        end else if (m_busy) begin
            if (m_run == WD_MAX) begin
                m_busy = 0; m_done = 1; m_to = 1;
            end else begin
                m_run++;
                if (!stall) begin
                    if (halt) begin
                        m_busy = 0; m_done = 1;
                    end else begin
                        if (absjump_en)      np = m_lut[lut_idx];
                        else if (reljump_en) np = m_pc + rel_off;
                        else                 np = m_pc + 1;
                        m_pc = np;
                        if (np == D'(ENDA)) begin
                            m_busy = 0; m_done = 1;
                        end
                    end
                end
            end
        end else if (m_done) begin
            if (!req) m_done = 0;
        end else if (req) begin
            m_busy = 1; m_pc = D'(START); m_run = 0; m_to = 0;
        end
        if (lut_we) m_lut[lut_waddr] = lut_wdata;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; halt = 0; absjump_en = 0; reljump_en = 0;
        lut_idx = '0; rel_off = '0; lut_we = 0;
    endtask

    task automatic advance_to(input logic [D-1:0] target);
        int n = 0;
        while (m_pc != target && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (prog_ctr !== target) begin
            bad++;
            $display("FAIL advance_to: prog_ctr=%0d want %0d", prog_ctr, target);
        end
    endtask

    task automatic finish_run();
        halt = 1; tick(); halt = 0;
        req = 0; tick();
    endtask

    task automatic test_reset();
        reset = 1; req = 0; clear_inputs();
        tick(); tick();
        total++;
        if ({busy, done, timeout, fetch_valid} !== 4'b0000 || prog_ctr !== 12'd0) begin
            bad++;
            $display("FAIL reset: busy/done/to/fv=%b%b%b%b pc=%0d want 0000 pc=0",
                     busy, done, timeout, fetch_valid, prog_ctr);
        end
        reset = 0; tick();
    endtask

    task automatic test_linear();
        int errs = 0;
        req = 1; tick();
        total++;
        if (busy !== 1'b1 || prog_ctr !== 12'd0) begin
            bad++;
            $display("FAIL linear_start: busy=%b pc=%0d want busy=1 pc=0", busy, prog_ctr);
        end
        for (int i = 0; i < 128; i++) begin
            if (prog_ctr !== 12'(i) || busy !== 1'b1) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL linear_seq: %0d cycles off, want pc 0..127 while busy", errs);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || prog_ctr !== 12'd128) begin
            bad++;
            $display("FAIL linear_done: done=%b busy=%b pc=%0d want 1 0 128", done, busy, prog_ctr);
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_held: done=%b want 1", done);
        end
        req = 0; tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_drop: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_abs_priority();
        lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'd40; tick(); lut_we = 0;
        req = 1; tick();
        advance_to(12'd5);
        absjump_en = 1; reljump_en = 1; lut_idx = 5'd3; rel_off = 12'd7;
        tick();
        total++;
        if (prog_ctr !== 12'd40) begin
            bad++;
            $display("FAIL abs_priority: pc=%0d want 40", prog_ctr);
        end
        reljump_en = 0;
        lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'd60;
        tick();
        total++;
        if (prog_ctr !== 12'd40) begin
            bad++;
            $display("FAIL lut_old_entry: pc=%0d want 40", prog_ctr);
        end
        lut_we = 0;
        tick();
        total++;
        if (prog_ctr !== 12'd60) begin
            bad++;
            $display("FAIL lut_new_entry: pc=%0d want 60", prog_ctr);
        end
        clear_inputs();
        finish_run();
    endtask

    task automatic test_rel_wrap();
        req = 1; tick();
        advance_to(12'd10);
        reljump_en = 1; rel_off = 12'hFFC; tick();
        total++;
        if (prog_ctr !== 12'd6) begin
            bad++;
            $display("FAIL rel_negative: pc=%0d want 6", prog_ctr);
        end
        rel_off = 12'd4089; tick();
        total++;
        if (prog_ctr !== 12'd4095) begin
            bad++;
            $display("FAIL rel_positive: pc=%0d want 4095", prog_ctr);
        end
        clear_inputs(); tick();
        total++;
        if (prog_ctr !== 12'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pc_wrap: pc=%0d busy=%b want 0 1", prog_ctr, busy);
        end
        finish_run();
    endtask

    task automatic test_stall();
        req = 1; tick();
        advance_to(12'd7);
        stall = 1; halt = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (fetch_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_fv: fetch_valid=%b want 0", fetch_valid);
            end
            tick();
            total++;
            if (prog_ctr !== 12'd7 || busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold: pc=%0d busy=%b want 7 1", prog_ctr, busy);
            end
        end
        stall = 0; #1;
        total++;
        if (fetch_valid !== 1'b1) begin
            bad++;
            $display("FAIL unstall_fv: fetch_valid=%b want 1", fetch_valid);
        end
        tick();
        total++;
        if (done !== 1'b1 || prog_ctr !== 12'd7) begin
            bad++;
            $display("FAIL halt_done: done=%b pc=%0d want 1 7", done, prog_ctr);
        end
        halt = 0; req = 0; tick();
    endtask

    task automatic test_watchdog();
        int n = 0;
        reljump_en = 1; rel_off = 12'd0;
        req = 1; tick();
        while (busy === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        total++;
        if (n != WD_MAX + 1) begin
            bad++;
            $display("FAIL wd_cycles: run cycles=%0d want %0d", n, WD_MAX + 1);
        end
        total++;
        if (done !== 1'b1 || timeout !== 1'b1 || prog_ctr !== 12'd0) begin
            bad++;
            $display("FAIL wd_timeout: done=%b to=%b pc=%0d want 1 1 0", done, timeout, prog_ctr);
        end
        clear_inputs();
        req = 0; tick(); tick(); tick();
        total++;
        if (done !== 1'b0 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_held: done=%b to=%b want 0 1", done, timeout);
        end
        req = 1; tick();
        total++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_clear: busy=%b to=%b want 1 0", busy, timeout);
        end
        finish_run();
    endtask

    task automatic test_reset_mid_run();
        req = 1; tick();
        advance_to(12'd50);
        absjump_en = 1; lut_idx = 5'd3; reset = 1;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || prog_ctr !== 12'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b pc=%0d want 0 0 0", busy, done, prog_ctr);
        end
        reset = 0; clear_inputs(); tick();
        total++;
        if (busy !== 1'b1 || prog_ctr !== 12'd0) begin
            bad++;
            $display("FAIL restart: busy=%b pc=%0d want 1 0", busy, prog_ctr);
        end
        finish_run();
    endtask

    task automatic test_random();
        logic [D-1:0] want_pc;
        logic [3:0]   want_f, got_f;
        for (int i = 0; i < (1 << L); i++) begin
            lut_we = 1; lut_waddr = L'(i);
            lut_wdata = ($urandom_range(0, 3) == 0) ? 12'd128 : 12'($urandom_range(0, 4095));
            tick();
        end
        lut_we = 0;
        for (int r = 0; r < 8; r++) begin
            int n = 0;
            bit started = 0;
            req = 1;
            while (n < 700) begin
                stall      = ($urandom_range(0, 3) == 0);
                halt       = ($urandom_range(0, 49) == 0);
                absjump_en = ($urandom_range(0, 7) == 0);
                reljump_en = ($urandom_range(0, 7) == 0);
                lut_idx    = L'($urandom_range(0, (1 << L) - 1));
                rel_off    = 12'($urandom_range(0, 16)) - 12'd8;
                lut_we     = ($urandom_range(0, 9) == 0);
                lut_waddr  = L'($urandom_range(0, (1 << L) - 1));
                lut_wdata  = 12'($urandom_range(0, 4095));
                reset      = ($urandom_range(0, 299) == 0);
                if (m_busy) req = ($urandom_range(0, 19) != 0);
                else if (m_done) req = ($urandom_range(0, 2) != 0);
                #1;
                want_f  = {m_busy, m_done, m_to, m_busy && !stall};
                want_pc = m_pc;
                got_f   = {busy, done, timeout, fetch_valid};
                total++;
                if (got_f !== want_f || prog_ctr !== want_pc) begin
                    bad++;
                    $display("FAIL random r%0d c%0d: busy/done/to/fv=%b pc=%0d want %b pc=%0d",
                             r, n, got_f, prog_ctr, want_f, want_pc);
                end
                if (m_busy) started = 1;
                if (started && !m_busy && !m_done) break;
                if (!m_busy && !m_done) req = 1;
                tick();
                n++;
            end
            reset = 0; clear_inputs(); req = 0;
            tick(); tick();
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_abs_priority();
        test_rel_wrap();
        test_stall();
        test_watchdog();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
